// File: rtl/fpga_test_pattern_gen.sv
// Selectable test-pattern generator (counter, walking-one, Galois LFSR, static)
// paced by a programmable prescaler, plus binary-divided heartbeat LEDs.
module fpga_test_pattern_gen #(
  parameter int                    TEST_WIDTH      = 8,
  parameter int                    LED_COUNT       = 1,
  parameter int                    PRESCALE_WIDTH  = 16,
  parameter int                    HEARTBEAT_TICKS = 100,
  parameter logic [TEST_WIDTH-1:0] LFSR_TAPS       = 8'hB8,
  parameter logic [TEST_WIDTH-1:0] LFSR_SEED       = 8'h01
) (
  input  logic                      i_CLK,
  input  logic                      i_RESET_n,
  input  logic                      i_ENABLE,
  input  logic [1:0]                iv_MODE,
  input  logic [PRESCALE_WIDTH-1:0] iv_PRESCALE,
  input  logic [TEST_WIDTH-1:0]     iv_STATIC,
  input  logic                      i_LOAD,
  output logic [TEST_WIDTH-1:0]     ov_FPGA_TEST,
  output logic [LED_COUNT-1:0]      ov_LED,
  output logic                      o_TICK,
  output logic                      o_WRAP
);

  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [TEST_WIDTH-1:0] SEED_EFF =
    (LFSR_SEED == '0) ? TEST_WIDTH'(1) : LFSR_SEED;
  localparam int HB_W = (HEARTBEAT_TICKS > 1) ? $clog2(HEARTBEAT_TICKS) : 1;
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_TICKS - 1);

  typedef enum logic [1:0] {
    MODE_COUNT  = 2'd0,
    MODE_WALK   = 2'd1,
    MODE_LFSR   = 2'd2,
    MODE_STATIC = 2'd3
  } mode_t;

  mode_t                     mode_q, mode_d, mode_in;
  logic [TEST_WIDTH-1:0]     pattern_q, pattern_d, init_value, adv_value;
  logic [PRESCALE_WIDTH-1:0] count_q, count_d;
  logic [HB_W-1:0]           hb_q, hb_d;
  logic [LED_COUNT-1:0]      led_q, led_d;
  logic                      tick_q, tick_d, wrap_q, wrap_d;
  logic                      restart, tick_due, adv_wrap;

  always_comb begin
    mode_in  = mode_t'(iv_MODE);
    restart  = i_LOAD | (mode_in != mode_q);
    tick_due = (count_q >= iv_PRESCALE);
  end

  // Start value of the requested mode, and the next value of the running one.
  always_comb begin
    init_value = '0;
    adv_value  = pattern_q;
    adv_wrap   = 1'b0;
    case (mode_in)
      MODE_WALK:   init_value = TEST_WIDTH'(1);
      MODE_LFSR:   init_value = SEED_EFF;
      MODE_STATIC: init_value = iv_STATIC;
      default:     init_value = '0;
    endcase
    case (mode_q)
      MODE_COUNT: begin
        adv_value = pattern_q + 1'b1;
        adv_wrap  = &pattern_q;
      end
      MODE_WALK: begin
        adv_value = {pattern_q[TEST_WIDTH-2:0], pattern_q[TEST_WIDTH-1]};
        adv_wrap  = pattern_q[TEST_WIDTH-1];
      end
      MODE_LFSR: begin
        adv_value = (pattern_q >> 1) ^ (pattern_q[0] ? LFSR_TAPS : '0);
        adv_wrap  = (adv_value == SEED_EFF);
      end
      default: begin
        adv_value = iv_STATIC;
        adv_wrap  = 1'b0;
      end
    endcase
  end

  always_comb begin
    mode_d    = mode_q;
    pattern_d = pattern_q;
    count_d   = count_q;
    hb_d      = hb_q;
    led_d     = led_q;
    tick_d    = 1'b0;
    wrap_d    = 1'b0;
    if (i_ENABLE) begin
      if (restart) begin
        mode_d    = mode_in;
        pattern_d = init_value;
        count_d   = '0;
      end else begin
        if (mode_q == MODE_STATIC) begin
          pattern_d = iv_STATIC;
        end
        if (tick_due) begin
          count_d   = '0;
          tick_d    = 1'b1;
          wrap_d    = adv_wrap;
          pattern_d = adv_value;
          // Heartbeat follows ticks in every mode and survives restarts.
          if (hb_q == HB_LAST) begin
            hb_d  = '0;
            led_d = led_q + 1'b1;
          end else begin
            hb_d = hb_q + 1'b1;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RESET_n) begin
      mode_q    <= MODE_COUNT;
      pattern_q <= '0;
      count_q   <= '0;
      hb_q      <= '0;
      led_q     <= '0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      pattern_q <= pattern_d;
      count_q   <= count_d;
      hb_q      <= hb_d;
      led_q     <= led_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
    end
  end

  assign ov_FPGA_TEST = pattern_q;
  assign ov_LED       = led_q;
  assign o_TICK       = tick_q;
  assign o_WRAP       = wrap_q;

endmodule
